// File: rtl/sim_exit_responder.sv
// Purpose : memory-mapped test-exit responder; latches pass/fail/code and streams the signature range to the bench.
// Latency : bus response 1 cycle after acceptance; one signature word per 3 cycles at best (FETCH, WAIT, SEND).
// Backpressure: bus acceptance follows a rotating stall pattern; sig_valid/sig_data/sig_last hold until sig_ready.
// Ports   : clk/rst (async active-high); dmem_* register-window bus (req/ack, 1-cycle resp+rdata);
//           ack_pattern stall mask; sig_rd_* signature memory read port (data 1 cycle after req);
//           sig_valid/ready/data/last signature stream; test_done/pass/timeout/code status flags.
module sim_exit_responder #(
  parameter logic [31:0] SIM_EXIT_BASE = 32'hF000_0000,
  parameter logic [31:0] TIMEOUT       = 32'd2_000_000,
  parameter int          ADDR_W        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmem_req,
  input  logic              dmem_cmd,
  input  logic [1:0]        dmem_width,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [31:0]       dmem_wdata,
  output logic              dmem_req_ack,
  output logic [31:0]       dmem_rdata,
  output logic [1:0]        dmem_resp,
  input  logic [31:0]       ack_pattern,
  output logic              sig_rd_req,
  output logic [ADDR_W-1:0] sig_rd_addr,
  input  logic [31:0]       sig_rd_data,
  output logic              sig_valid,
  input  logic              sig_ready,
  output logic [31:0]       sig_data,
  output logic              sig_last,
  output logic              test_done,
  output logic              test_pass,
  output logic              test_timeout,
  output logic [30:0]       test_code
);

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(SIM_EXIT_BASE);
  localparam logic [1:0] RESP_IDLE  = 2'd0;
  localparam logic [1:0] RESP_OKAY  = 2'd1;
  localparam logic [1:0] RESP_ERROR = 2'd2;

  typedef enum logic [2:0] {S_RUN, S_FETCH, S_WAIT, S_SEND, S_DONE} state_t;

  state_t            r_state;
  logic [31:0]       r_wdog;
  logic [31:0]       r_pat;
  logic              r_pat_vld;
  logic [ADDR_W-1:0] r_begin;
  logic [ADDR_W-1:0] r_end;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_hi;
  logic              r_rd_req;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_sig_vld;
  logic [31:0]       r_sig_dat;
  logic              r_sig_last;
  logic              r_done;
  logic              r_pass;
  logic              r_tmo;
  logic [30:0]       r_code;
  logic [1:0]        r_resp;
  logic [31:0]       r_rdata;

  logic [ADDR_W-1:0] w_off;
  logic [1:0]        w_sel;
  logic              w_err;
  logic              w_ack;
  logic              w_wr_ok;
  logic              w_exit;
  logic              w_busy;
  logic [ADDR_W-1:0] w_min;
  logic [ADDR_W-1:0] w_max;
  logic [ADDR_W-1:0] w_lo;
  logic [ADDR_W-1:0] w_hi;
  logic [ADDR_W-1:0] w_ptr_nxt;
  logic [31:0]       w_rd_val;

  // Only the four word registers at offsets 0x0..0xC decode; everything else is an error.
  assign w_off     = dmem_addr - BASE;
  assign w_sel     = w_off[3:2];
  assign w_err     = (w_off[ADDR_W-1:4] != '0) || (w_off[1:0] != 2'b00) || (dmem_width != 2'd2);

  // Nothing is accepted until the stall pattern has been captured after reset release.
  assign w_ack     = dmem_req & r_pat_vld & r_pat[0];
  assign w_wr_ok   = w_ack & dmem_cmd & ~w_err;
  assign w_exit    = w_wr_ok & (w_sel == 2'd0) & dmem_wdata[0] & (r_state == S_RUN);
  assign w_busy    = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_SEND);

  assign w_min     = (r_begin < r_end) ? r_begin : r_end;
  assign w_max     = (r_begin < r_end) ? r_end   : r_begin;
  assign w_lo      = {w_min[ADDR_W-1:2], 2'b00};
  assign w_hi      = {w_max[ADDR_W-1:2], 2'b00};
  assign w_ptr_nxt = r_ptr + ADDR_W'(4);

  always_comb begin
    w_rd_val = 32'd0;
    case (w_sel)
      2'd1:    w_rd_val = 32'(r_begin);
      2'd2:    w_rd_val = 32'(r_end);
      2'd3:    w_rd_val = {28'd0, w_busy, r_tmo, r_pass, r_done};
      default: w_rd_val = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_wdog     <= 32'd0;
      r_pat      <= 32'd0;
      r_pat_vld  <= 1'b0;
      r_begin    <= '0;
      r_end      <= '0;
      r_ptr      <= '0;
      r_hi       <= '0;
      r_rd_req   <= 1'b0;
      r_rd_addr  <= '0;
      r_sig_vld  <= 1'b0;
      r_sig_dat  <= 32'd0;
      r_sig_last <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_tmo      <= 1'b0;
      r_code     <= 31'd0;
      r_resp     <= RESP_IDLE;
      r_rdata    <= 32'd0;
    end else begin
      // An all-zero pattern would deadlock the bus, so it is promoted to always-accept.
      if (!r_pat_vld) begin
        r_pat     <= (ack_pattern == 32'd0) ? 32'hFFFF_FFFF : ack_pattern;
        r_pat_vld <= 1'b1;
      end else begin
        r_pat <= {r_pat[0], r_pat[31:1]};
      end

      if (w_ack) begin
        r_resp  <= w_err ? RESP_ERROR : RESP_OKAY;
        r_rdata <= (w_err || dmem_cmd) ? 32'd0 : w_rd_val;
      end else begin
        r_resp  <= RESP_IDLE;
        r_rdata <= 32'd0;
      end

      if (w_wr_ok && (w_sel == 2'd1)) r_begin <= ADDR_W'(dmem_wdata);
      if (w_wr_ok && (w_sel == 2'd2)) r_end   <= ADDR_W'(dmem_wdata);

      case (r_state)
        S_RUN: begin
          r_wdog <= r_wdog + 32'd1;
          // A firmware exit in the final watchdog cycle takes priority over the timeout.
          if (w_exit) begin
            r_code <= dmem_wdata[31:1];
            r_pass <= (dmem_wdata[31:1] == 31'd0);
            r_ptr  <= w_lo;
            r_hi   <= w_hi;
            if (w_lo == w_hi) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_FETCH;
              r_rd_req  <= 1'b1;
              r_rd_addr <= w_lo;
            end
          end else if (r_wdog == TIMEOUT - 32'd1) begin
            r_tmo   <= 1'b1;
            r_pass  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_FETCH: begin
          r_rd_req <= 1'b0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          r_sig_dat  <= sig_rd_data;
          r_sig_vld  <= 1'b1;
          r_sig_last <= (w_ptr_nxt == r_hi);
          r_state    <= S_SEND;
        end
        S_SEND: begin
          if (sig_ready) begin
            r_sig_vld  <= 1'b0;
            r_sig_last <= 1'b0;
            r_ptr      <= w_ptr_nxt;
            if (r_sig_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state   <= S_FETCH;
              r_rd_req  <= 1'b1;
              r_rd_addr <= w_ptr_nxt;
            end
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: r_state <= S_RUN;
      endcase
    end
  end

  assign dmem_req_ack = w_ack;
  assign dmem_resp    = r_resp;
  assign dmem_rdata   = r_rdata;
  assign sig_rd_req   = r_rd_req;
  assign sig_rd_addr  = r_rd_addr;
  assign sig_valid    = r_sig_vld;
  assign sig_data     = r_sig_dat;
  assign sig_last     = r_sig_last;
  assign test_done    = r_done;
  assign test_pass    = r_pass;
  assign test_timeout = r_tmo;
  assign test_code    = r_code;

endmodule

// File: tb/tb_sim_exit_responder.sv
// Purpose : directed bench for sim_exit_responder: pass/fail exits, backpressure, watchdog, bus errors, resets.
// Latency : expects bus response one cycle after acceptance and one rd_req pulse per streamed word.
// Backpressure: bench drives sig_ready and checks the stream holds while stalled.
module tb_sim_exit_responder;

  localparam logic [31:0] BASE = 32'hF000_0000;
  localparam logic [31:0] A_EXIT = BASE + 32'h0;
  localparam logic [31:0] A_BEG  = BASE + 32'h4;
  localparam logic [31:0] A_END  = BASE + 32'h8;
  localparam logic [31:0] A_STAT = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst;
  logic        dmem_req;
  logic        dmem_cmd;
  logic [1:0]  dmem_width;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic        dmem_req_ack;
  logic [31:0] dmem_rdata;
  logic [1:0]  dmem_resp;
  logic [31:0] ack_pattern;
  logic        sig_rd_req;
  logic [31:0] sig_rd_addr;
  logic [31:0] sig_rd_data;
  logic        sig_valid;
  logic        sig_ready;
  logic [31:0] sig_data;
  logic        sig_last;
  logic        test_done;
  logic        test_pass;
  logic        test_timeout;
  logic [30:0] test_code;

  always #5 clk = ~clk;

  sim_exit_responder #(
    .SIM_EXIT_BASE(BASE),
    .TIMEOUT      (32'd100),
    .ADDR_W       (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dmem_req    (dmem_req),
    .dmem_cmd    (dmem_cmd),
    .dmem_width  (dmem_width),
    .dmem_addr   (dmem_addr),
    .dmem_wdata  (dmem_wdata),
    .dmem_req_ack(dmem_req_ack),
    .dmem_rdata  (dmem_rdata),
    .dmem_resp   (dmem_resp),
    .ack_pattern (ack_pattern),
    .sig_rd_req  (sig_rd_req),
    .sig_rd_addr (sig_rd_addr),
    .sig_rd_data (sig_rd_data),
    .sig_valid   (sig_valid),
    .sig_ready   (sig_ready),
    .sig_data    (sig_data),
    .sig_last    (sig_last),
    .test_done   (test_done),
    .test_pass   (test_pass),
    .test_timeout(test_timeout),
    .test_code   (test_code)
  );

  int          n_chk  = 0;
  int          n_pass = 0;
  int          n_rdreq;
  int          n_vld;
  logic [31:0] q_dat[$];
  logic        q_last[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h100: mem_rd = 32'hA;
      32'h104: mem_rd = 32'hB;
      32'h108: mem_rd = 32'hC;
      default: mem_rd = a ^ 32'h5A5A_0000;
    endcase
  endfunction

  // Signature memory: data is only meaningful in the cycle right after the read strobe.
  always @(posedge clk) begin
    if (sig_rd_req) sig_rd_data <= mem_rd(sig_rd_addr);
    else            sig_rd_data <= 32'hDEAD_BEEF;
  end

  // Stream monitor and strobe counters, cleared while reset is held.
  always @(posedge clk) begin
    if (rst) begin
      n_rdreq <= 0;
      n_vld   <= 0;
      q_dat.delete();
      q_last.delete();
    end else begin
      if (sig_rd_req) n_rdreq <= n_rdreq + 1;
      if (sig_valid)  n_vld   <= n_vld + 1;
      if (sig_valid && sig_ready) begin
        q_dat.push_back(sig_data);
        q_last.push_back(sig_last);
      end
    end
  end

  task automatic do_reset(input logic [31:0] pat);
    rst         = 1'b1;
    ack_pattern = pat;
    dmem_req    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic bus(input logic cmd, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                     output logic [1:0] resp, output logic [31:0] rd);
    int n;
    n = 0;
    dmem_req = 1'b1; dmem_cmd = cmd; dmem_width = w; dmem_addr = a; dmem_wdata = d;
    @(negedge clk);
    while (!dmem_req_ack && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("bus_ack", {31'd0, dmem_req_ack}, 32'd1);
    @(posedge clk);
    #1;
    dmem_req = 1'b0;
    resp     = dmem_resp;
    rd       = dmem_rdata;
  endtask

  task automatic wr(input string tag, input logic [1:0] w, input logic [31:0] a, input logic [31:0] d,
                    input logic [1:0] er);
    logic [1:0]  r;
    logic [31:0] x;
    bus(1'b1, w, a, d, r, x);
    chk(tag, {30'd0, r}, {30'd0, er});
  endtask

  task automatic rdc(input string tag, input logic [1:0] w, input logic [31:0] a, input logic [1:0] er,
                     input logic [31:0] ed);
    logic [1:0]  r;
    logic [31:0] x;
    bus(1'b0, w, a, 32'd0, r, x);
    chk({tag, "_resp"}, {30'd0, r}, {30'd0, er});
    chk({tag, "_dat"}, x, ed);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!test_done && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(tag, {31'd0, test_done}, 32'd1);
  endtask

  task automatic wait_vld(input string tag);
    int n;
    n = 0;
    while (!sig_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, sig_valid}, 32'd1);
  endtask

  initial begin
    logic exp_ack;
    logic prev_ack;
    int   n;
    sig_ready = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'd2; dmem_addr = 32'd0; dmem_wdata = 32'd0;

    // ---- reset state, bus errors, pass exit (pattern 0 behaves as all ones) ----
    rst = 1'b1; ack_pattern = 32'd0; dmem_req = 1'b1; dmem_addr = A_STAT;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack",  {31'd0, dmem_req_ack}, 32'd0);
    chk("rst_resp", {30'd0, dmem_resp}, 32'd0);
    chk("rst_flags", {28'd0, sig_valid, sig_rd_req, test_done, test_pass}, 32'd0);
    chk("rst_code", {1'b0, test_code}, 32'd0);
    do_reset(32'd0);
    wr ("byte_exit", 2'd0, A_EXIT, 32'd1, 2'd2);
    rdc("rd_0x10",   2'd2, BASE + 32'h10, 2'd2, 32'd0);
    rdc("half_beg",  2'd1, A_BEG, 2'd2, 32'd0);
    rdc("unalign",   2'd2, BASE + 32'h5, 2'd2, 32'd0);
    chk("err_nodone", {31'd0, test_done}, 32'd0);
    wr ("w_beg", 2'd2, A_BEG, 32'h100, 2'd1);
    rdc("r_beg", 2'd2, A_BEG, 2'd1, 32'h100);
    wr ("w_end", 2'd2, A_END, 32'h10C, 2'd1);
    wr ("w_stat", 2'd2, A_STAT, 32'hF, 2'd1);
    rdc("stat0", 2'd2, A_STAT, 2'd1, 32'd0);
    wr ("exit_b0", 2'd2, A_EXIT, 32'h0, 2'd1);
    chk("exit_b0_nobusy", {31'd0, sig_rd_req | test_done}, 32'd0);
    wr ("exit1", 2'd2, A_EXIT, 32'h1, 2'd1);
    wait_done("p_done");
    chk("p_beats", q_dat.size(), 32'd3);
    if (q_dat.size() == 3) begin
      chk("p_d0", q_dat[0], 32'hA); chk("p_d1", q_dat[1], 32'hB); chk("p_d2", q_dat[2], 32'hC);
      chk("p_last", {29'd0, q_last[0], q_last[1], q_last[2]}, 32'b001);
    end
    chk("p_pass",  {31'd0, test_pass}, 32'd1);
    chk("p_code",  {1'b0, test_code}, 32'd0);
    chk("p_rdreq", n_rdreq, 32'd3);
    rdc("p_stat", 2'd2, A_STAT, 2'd1, 32'h3);
    rdc("p_exit_rd", 2'd2, A_EXIT, 2'd1, 32'd0);
    wr ("p_exit_again", 2'd2, A_EXIT, 32'hFF, 2'd1);
    chk("p_code_kept", {1'b0, test_code}, 32'd0);

    // ---- fail code, swapped bounds, backpressure on beat 2 ----
    do_reset(32'd0);
    wr("f_beg", 2'd2, A_BEG, 32'h208, 2'd1);
    wr("f_end", 2'd2, A_END, 32'h200, 2'd1);
    wr("f_exit", 2'd2, A_EXIT, 32'h7, 2'd1);
    n = 0;
    while (q_dat.size() < 1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    sig_ready = 1'b0;
    wait_vld("f_vld2");
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld",  {31'd0, sig_valid}, 32'd1);
      chk("bp_dat",  sig_data, 32'h5A5A_0204);
      chk("bp_last", {31'd0, sig_last}, 32'd1);
      @(negedge clk);
    end
    sig_ready = 1'b1;
    wait_done("f_done");
    chk("f_beats", q_dat.size(), 32'd2);
    if (q_dat.size() == 2) begin
      chk("f_d0", q_dat[0], 32'h5A5A_0200); chk("f_d1", q_dat[1], 32'h5A5A_0204);
      chk("f_last", {30'd0, q_last[0], q_last[1]}, 32'b01);
    end
    chk("f_pass",  {31'd0, test_pass}, 32'd0);
    chk("f_code",  {1'b0, test_code}, 32'd3);
    chk("f_rdreq", n_rdreq, 32'd2);

    // ---- watchdog: fires on the 100th RUN cycle ----
    do_reset(32'd0);
    repeat (99) @(posedge clk);
    #1;
    chk("to_early", {31'd0, test_done}, 32'd0);
    @(posedge clk);
    #1;
    chk("to_flags", {29'd0, test_timeout, test_pass, test_done}, 32'b101);
    rdc("to_stat", 2'd2, A_STAT, 2'd1, 32'h5);
    chk("to_novld", n_vld, 32'd0);

    // ---- EXIT accepted in the watchdog's final cycle wins ----
    do_reset(32'd0);
    repeat (99) @(posedge clk);
    #1;
    dmem_req = 1'b1; dmem_cmd = 1'b1; dmem_width = 2'd2; dmem_addr = A_EXIT; dmem_wdata = 32'h1;
    @(posedge clk);
    #1;
    dmem_req = 1'b0;
    chk("lx_resp",  {30'd0, dmem_resp}, 32'd1);
    chk("lx_flags", {29'd0, test_timeout, test_pass, test_done}, 32'b011);

    // ---- empty range ----
    do_reset(32'd0);
    wr("e_beg", 2'd2, A_BEG, 32'h300, 2'd1);
    wr("e_end", 2'd2, A_END, 32'h300, 2'd1);
    wr("e_exit", 2'd2, A_EXIT, 32'h1, 2'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("e_done",  {30'd0, test_done, test_pass}, 32'b11);
    chk("e_beats", q_dat.size(), 32'd0);
    chk("e_rdreq", n_rdreq, 32'd0);

    // ---- stall pattern 0x5: accepts only on phases 0 and 2 ----
    do_reset(32'h0000_0005);
    dmem_req = 1'b1; dmem_cmd = 1'b0; dmem_width = 2'd2; dmem_addr = A_STAT;
    #1;
    chk("pat_unloaded", {31'd0, dmem_req_ack}, 32'd0);
    prev_ack = 1'b0;
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      exp_ack = (((k - 1) % 32) == 0) || (((k - 1) % 32) == 2);
      chk("pat_ack",  {31'd0, dmem_req_ack}, {31'd0, exp_ack});
      chk("pat_resp", {30'd0, dmem_resp}, {31'd0, prev_ack});
      prev_ack = exp_ack;
    end
    dmem_req = 1'b0;

    // ---- reset asserted mid-SEND ----
    do_reset(32'd0);
    sig_ready = 1'b0;
    wr("m_beg", 2'd2, A_BEG, 32'h100, 2'd1);
    wr("m_end", 2'd2, A_END, 32'h10C, 2'd1);
    wr("m_exit", 2'd2, A_EXIT, 32'h1, 2'd1);
    wait_vld("m_vld");
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("m_rst_out", {28'd0, sig_valid, sig_rd_req, test_done, test_pass}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    sig_ready = 1'b1;
    rdc("m_stat", 2'd2, A_STAT, 2'd1, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sim_exit_responder.md
Name: sim_exit_responder

Overview:
- Synthesizable memory-mapped test-exit responder on the core data bus, at SIM_EXIT_BASE.
- Firmware writes the signature bounds and an exit code. The block latches pass/fail, then streams the signature words from test memory to the bench over a valid/ready port.
- It is the DUT-side writer of test status and signature; the bench only consumes the stream and the status flags.

Parameters:
- SIM_EXIT_BASE, 32'hF000_0000, byte base address of the register window (low 5 bits are 0).
- TIMEOUT, 32'd2_000_000, cycles in RUN before a forced timeout exit.
- ADDR_W, 32, address width of bus and memory read port.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- dmem_req  in  1  bus request
- dmem_cmd  in  1  0=read, 1=write
- dmem_width  in  2  0=byte, 1=half, 2=word
- dmem_addr  in  ADDR_W  byte address
- dmem_wdata  in  32  write data
- dmem_req_ack  out  1  request accepted this cycle
- dmem_rdata  out  32  read data, valid with resp
- dmem_resp  out  2  0=IDLE, 1=OKAY, 2=ERROR
- ack_pattern  in  32  stall pattern, sampled at reset release
- sig_rd_req  out  1  signature memory read strobe
- sig_rd_addr  out  ADDR_W  word-aligned read address
- sig_rd_data  in  32  read data, exactly 1 cycle after sig_rd_req
- sig_valid  out  1  signature word valid
- sig_ready  in  1  bench ready
- sig_data  out  32  signature word
- sig_last  out  1  final word of signature
- test_done  out  1  sticky, test finished
- test_pass  out  1  sticky, valid when test_done
- test_timeout  out  1  sticky, watchdog fired
- test_code  out  31  exit code (wdata[31:1])

Behaviour:
- Reset: all outputs 0; dmem_resp=IDLE; FSM=RUN; watchdog=0; the ack pattern register loads ack_pattern on the first clk after rst falls.
- Ack: dmem_req_ack = dmem_req & pat[0]. The pattern rotates right by 1 every cycle in RUN and in later states. A pattern of all zeros is treated as all ones.
- Response:
  - An accepted access (req & ack) gets dmem_resp exactly 1 cycle later; otherwise resp=IDLE.
  - ERROR when the offset is not in {0x0, 0x4, 0x8, 0xC}, when addr[1:0]!=0, or when width!=2. On ERROR no register changes and rdata=0.
- Registers, by offset:
  - 0x0 EXIT, write-only, reads 0. A write with wdata[0]=1 while in RUN sets test_code=wdata[31:1] and test_pass=(wdata[31:1]==0), then goes to FETCH. A write with wdata[0]=0, or in any other state, is ignored but answered OKAY.
  - 0x4 SIG_BEGIN, R/W.
  - 0x8 SIG_END, R/W.
  - 0xC STATUS, read-only: {28'b0, busy, timeout, pass, done}. Writes are answered OKAY and ignored.
- Signature range: lo=min(BEGIN,END)&~3 and hi=max(BEGIN,END)&~3, computed at the EXIT write. If lo==hi, skip to DONE with no words streamed.
- FSM states: RUN, FETCH, WAIT, SEND, DONE.
  - RUN: the watchdog increments each cycle. At watchdog==TIMEOUT-1, set test_timeout=1, test_pass=0, test_done=1, and go to DONE with no dump. If an EXIT write is accepted in the same cycle, the EXIT write wins.
  - FETCH: sig_rd_req=1 for one cycle with sig_rd_addr=ptr, then go to WAIT.
  - WAIT: capture sig_rd_data into sig_data, set sig_valid=1 and sig_last=(ptr+4==hi), then go to SEND.
  - SEND: hold sig_data and sig_last stable while valid & ~ready. On valid & ready, ptr+=4. If last, go to DONE; else go to FETCH.
  - DONE: test_done=1 and the FSM holds until rst. Bus accesses are still serviced; STATUS reads stay available.
- Flags: test_done rises when DONE is entered. busy=1 in FETCH, WAIT and SEND.
- Throughput: at most 1 word per 3 cycles. sig_valid never deasserts without a handshake.
- Address arithmetic: ptr wraps modulo 2^ADDR_W. A range that crosses the top of memory is not supported.
- Reset mid-dump: asserting rst drops sig_valid immediately (async), clears all flags, and returns to RUN.

Test Plan:
- Pass exit: write BEGIN=0x100, END=0x10C, then EXIT=0x1; memory holds 0xA,0xB,0xC at 0x100..0x108 -> three stream beats 0xA,0xB,0xC, sig_last only on the third; test_done=1, test_pass=1, test_code=0.
- Fail code and swapped bounds: BEGIN=0x208, END=0x200, EXIT=0x7 -> two words from 0x200 and 0x204; test_pass=0, test_code=3.
- Backpressure: sig_ready low 5 cycles on beat 2 -> sig_data and sig_last stable throughout; no duplicate or dropped words; sig_rd_req pulses exactly once per word.
- Timeout: TIMEOUT=100, no EXIT write -> at cycle 100 test_timeout=1, test_done=1, test_pass=0, sig_valid never asserted; EXIT written in the TIMEOUT-1 cycle instead -> normal pass.
- Bus protocol: ack_pattern=32'h0000_0005 -> acks only on pattern phases 0 and 2; byte write to 0x0 -> ERROR with no exit; read of 0x10 -> ERROR; STATUS read after pass -> 0x3.
- Empty range and reset: BEGIN=END=0x300 with EXIT=1 -> no beats, done=1; rst asserted mid-SEND -> sig_valid=0 same cycle, flags cleared.
